// File: rtl/wtc_pkg.sv
// Shared definitions for the two-digit BCD display counter: FSM encodings and
// the BCD digit ceiling.
package wtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN_UP   = 2'b01,
        ST_RUN_DOWN = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/wtc_bcd_digit.sv
// One BCD digit stepper: computes the next digit value for an increment or
// decrement and flags the carry/borrow into the next digit.
module wtc_bcd_digit
    import wtc_pkg::*;
(
    input  logic [3:0] i_Digit,
    input  logic       i_Inc,
    input  logic       i_Dec,
    output logic [3:0] o_Digit,
    output logic       o_Carry,
    output logic       o_Borrow
);

    always_comb begin
        o_Digit  = i_Digit;
        o_Carry  = 1'b0;
        o_Borrow = 1'b0;
        if (i_Inc && !i_Dec) begin
            // >= also folds any illegal code back into range
            if (i_Digit >= BCD_MAX) begin
                o_Digit = 4'd0;
                o_Carry = 1'b1;
            end else begin
                o_Digit = i_Digit + 4'd1;
            end
        end else if (i_Dec && !i_Inc) begin
            if (i_Digit == 4'd0) begin
                o_Digit  = BCD_MAX;
                o_Borrow = 1'b1;
            end else begin
                o_Digit = i_Digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/display_count_ctrl.sv
// Two-digit BCD up/down counter driven by switch-release events, with an
// IDLE/RUN_UP/RUN_DOWN mode FSM that auto-steps every CLKS_PER_TICK cycles.
module display_count_ctrl
    import wtc_pkg::*;
#(
    parameter int CLKS_PER_TICK = 500000
)
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Mode,
    input  logic       i_Clr,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic [1:0] o_State,
    output logic       o_Tick,
    output logic       o_Wrap
);

    localparam logic [31:0] TICK_LAST = 32'(CLKS_PER_TICK - 1);

    logic        r_up_q, r_down_q, r_mode_q, r_clr_q;
    state_t      r_state, w_state_next;
    logic [31:0] r_tick_cnt, w_tick_next;
    logic [3:0]  r_tens, r_ones;
    logic        r_tick, r_wrap;

    logic w_up_ev, w_dn_ev, w_mode_ev, w_clr_ev;
    logic w_running, w_tick_term, w_btn, w_auto;
    logic w_step_up, w_step_dn;
    logic [3:0] w_ones_next, w_tens_next;
    logic w_ones_carry, w_ones_borrow, w_tens_carry, w_tens_borrow;

    assign w_up_ev   = r_up_q   & ~i_Up;
    assign w_dn_ev   = r_down_q & ~i_Down;
    assign w_mode_ev = r_mode_q & ~i_Mode;
    assign w_clr_ev  = r_clr_q  & ~i_Clr;

    assign w_running   = (r_state != ST_IDLE);
    assign w_tick_term = w_running && (r_tick_cnt == TICK_LAST);
    // Any button event (even a cancelling UP+DOWN pair) pre-empts the auto-step.
    assign w_btn  = w_up_ev | w_dn_ev;
    assign w_auto = w_tick_term && !w_btn && !w_mode_ev && !w_clr_ev;

    assign w_step_up = !w_clr_ev && !w_mode_ev &&
                       ((w_up_ev && !w_dn_ev) || (w_auto && r_state == ST_RUN_UP));
    assign w_step_dn = !w_clr_ev && !w_mode_ev &&
                       ((w_dn_ev && !w_up_ev) || (w_auto && r_state == ST_RUN_DOWN));

    always_comb begin
        w_state_next = r_state;
        if (w_mode_ev && !w_clr_ev) begin
            case (r_state)
                ST_IDLE:     w_state_next = ST_RUN_UP;
                ST_RUN_UP:   w_state_next = ST_RUN_DOWN;
                ST_RUN_DOWN: w_state_next = ST_IDLE;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tick_next = r_tick_cnt + 32'd1;
        if (w_clr_ev || w_mode_ev || !w_running || w_tick_term) begin
            w_tick_next = '0;
        end
    end

    wtc_bcd_digit u_ones (
        .i_Digit  (r_ones),
        .i_Inc    (w_step_up),
        .i_Dec    (w_step_dn),
        .o_Digit  (w_ones_next),
        .o_Carry  (w_ones_carry),
        .o_Borrow (w_ones_borrow)
    );

    wtc_bcd_digit u_tens (
        .i_Digit  (r_tens),
        .i_Inc    (w_ones_carry),
        .i_Dec    (w_ones_borrow),
        .o_Digit  (w_tens_next),
        .o_Carry  (w_tens_carry),
        .o_Borrow (w_tens_borrow)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_up_q     <= 1'b0;
            r_down_q   <= 1'b0;
            r_mode_q   <= 1'b0;
            r_clr_q    <= 1'b0;
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_tens     <= 4'd0;
            r_ones     <= 4'd0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_up_q     <= i_Up;
            r_down_q   <= i_Down;
            r_mode_q   <= i_Mode;
            r_clr_q    <= i_Clr;
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_tens     <= w_clr_ev ? 4'd0 : w_tens_next;
            r_ones     <= w_clr_ev ? 4'd0 : w_ones_next;
            r_tick     <= w_auto;
            r_wrap     <= w_tens_carry | w_tens_borrow;
        end
    end

    assign o_Tens  = r_tens;
    assign o_Ones  = r_ones;
    assign o_State = r_state;
    assign o_Tick  = r_tick;
    assign o_Wrap  = r_wrap;

endmodule

// File: tb/tb_display_count_ctrl.sv
// Randomised and directed bench for display_count_ctrl against an integer
// reference model, with a per-cycle expected-response scoreboard.
module tb_display_count_ctrl;

  localparam int CPT = 4;

  logic       clk;
  logic       i_Rst, i_Up, i_Down, i_Mode, i_Clr;
  logic [3:0] o_Tens, o_Ones;
  logic [1:0] o_State;
  logic       o_Tick, o_Wrap;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];

  // reference model state
  int m_cnt = 0;
  int m_st = 0;
  int m_tick = 0;
  bit m_pu = 0, m_pd = 0, m_pm = 0, m_pc = 0;

  display_count_ctrl #(.CLKS_PER_TICK(CPT)) dut (
    .i_Clk   (clk),
    .i_Rst   (i_Rst),
    .i_Up    (i_Up),
    .i_Down  (i_Down),
    .i_Mode  (i_Mode),
    .i_Clr   (i_Clr),
    .o_Tens  (o_Tens),
    .o_Ones  (o_Ones),
    .o_State (o_State),
    .o_Tick  (o_Tick),
    .o_Wrap  (o_Wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    errors++;
    $fatal(1, "watchdog expired");
  end

  // reference model: one clock edge with the given input levels
  task automatic model_step(input bit up, input bit dn, input bit md, input bit cl,
                            input bit rs, output logic [11:0] e);
    bit eu, ed, em, ec, term, tk, wr;
    tk = 0;
    wr = 0;
    if (rs) begin
      m_cnt = 0; m_st = 0; m_tick = 0;
      m_pu = 0; m_pd = 0; m_pm = 0; m_pc = 0;
    end else begin
      eu = m_pu && !up;
      ed = m_pd && !dn;
      em = m_pm && !md;
      ec = m_pc && !cl;
      m_pu = up; m_pd = dn; m_pm = md; m_pc = cl;
      if (ec) begin
        m_cnt = 0;
        m_tick = 0;
      end else if (em) begin
        m_st = (m_st + 1) % 3;
        m_tick = 0;
      end else begin
        term = (m_st != 0) && (m_tick == CPT - 1);
        m_tick = (m_st == 0 || term) ? 0 : m_tick + 1;
        if (eu || ed) begin
          if (eu && !ed) begin
            wr = (m_cnt == 99);
            m_cnt = (m_cnt + 1) % 100;
          end else if (ed && !eu) begin
            wr = (m_cnt == 0);
            m_cnt = (m_cnt + 99) % 100;
          end
        end else if (term) begin
          tk = 1;
          if (m_st == 1) begin
            wr = (m_cnt == 99);
            m_cnt = (m_cnt + 1) % 100;
          end else begin
            wr = (m_cnt == 0);
            m_cnt = (m_cnt + 99) % 100;
          end
        end
      end
    end
    e = {4'(m_cnt / 10), 4'(m_cnt % 10), 2'(m_st), tk, wr};
  endtask

  // driver: apply levels for one cycle, push expectation at the edge
  task automatic drive(input bit up, input bit dn, input bit md, input bit cl, input bit rs);
    logic [11:0] e;
    @(negedge clk);
    i_Up = up; i_Down = dn; i_Mode = md; i_Clr = cl; i_Rst = rs;
    model_step(up, dn, md, cl, rs, e);
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // mask bits: [3]=clr [2]=mode [1]=down [0]=up; press cycle then release cycle
  task automatic release_btn(input logic [3:0] mask);
    drive(mask[0], mask[1], mask[2], mask[3], 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_count(input int n);
    release_btn(4'b1000);
    for (int i = 0; i < n; i++) release_btn(4'b0001);
  endtask

  // directed spot check against constants, sampled just after the edge
  task automatic check_now(input string name, input int tens, input int ones, input int st);
    #1;
    checks++;
    if (o_Tens !== 4'(tens) || o_Ones !== 4'(ones) || o_State !== 2'(st)) begin
      errors++;
      $display("FAIL %s: got %0d%0d state=%0d, required %0d%0d state=%0d",
               name, o_Tens, o_Ones, o_State, tens, ones, st);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [11:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {o_Tens, o_Ones, o_State, o_Tick, o_Wrap};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle@%0t: got tens=%0d ones=%0d state=%0d tick=%0b wrap=%0b, required tens=%0d ones=%0d state=%0d tick=%0b wrap=%0b",
                   $time, a[11:8], a[7:4], a[3:2], a[1], a[0], e[11:8], e[7:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    i_Up = 0; i_Down = 0; i_Mode = 0; i_Clr = 0; i_Rst = 1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_now("reset", 0, 0, 0);

    for (int i = 0; i < 12; i++) release_btn(4'b0001);
    check_now("twelve_up", 1, 2, 0);

    for (int i = 0; i < 13; i++) release_btn(4'b0010);
    check_now("down_wrap_to_99", 9, 9, 0);
    release_btn(4'b0001);
    check_now("up_wrap_to_00", 0, 0, 0);
    release_btn(4'b0010);
    check_now("down_wrap_again", 9, 9, 0);
    release_btn(4'b0001);

    release_btn(4'b0100);
    idle(20);
    check_now("run_up_20", 0, 5, 1);
    release_btn(4'b0100);
    idle(12);
    release_btn(4'b0100);
    idle(10);

    set_count(42);
    release_btn(4'b0011);
    check_now("up_down_cancel", 4, 2, 0);
    release_btn(4'b0100);
    idle(2);
    release_btn(4'b0001);
    check_now("up_on_terminal", 4, 3, 1);
    idle(6);

    release_btn(4'b0100);
    release_btn(4'b0100);
    set_count(57);
    release_btn(4'b0100);
    release_btn(4'b1000);
    check_now("clear_in_run_up", 0, 0, 1);
    idle(6);
    release_btn(4'b1001);
    check_now("clear_with_up", 0, 0, 1);

    release_btn(4'b0100);
    idle(10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_now("reset_mid_run", 0, 0, 0);
    idle(15);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check_now("held_through_reset", 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 99) == 0));
    end
    idle(3);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
